// File: rtl/wgt_loader.sv
`default_nettype none
// ==========================================================================
// wgt_loader : packs int8 weight bytes into TN-byte rows, ping-pong banks
// Revision   : 1.0
// ==========================================================================
module wgt_loader #(
  parameter int TN         = 14,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  input  logic [7:0]            cfg_tiles,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [TN*8-1:0]       wdata,
  output logic                  bank_sel_wr,
  output logic                  bank_valid,
  output logic                  bank_sel_rd,
  input  logic                  bank_release,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = (TN > 1) ? $clog2(TN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   rows_q, rows_d;
  logic [7:0]            tiles_q, tiles_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [TN*8-1:0]       pack_q, pack_d;
  logic                  we_q, we_d;
  logic                  final_q, final_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [TN*8-1:0]       wdata_q, wdata_d;
  logic                  bank_sel_wr_q, bank_sel_wr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic                  done_q, done_d;

  logic w_accept;
  logic w_last_byte;
  logic w_last_row;
  logic w_start_ok;
  logic w_row_done;
  logic w_release;

  assign w_accept    = s_valid && s_ready;
  assign w_last_byte = (byte_cnt_q == BCW'(TN - 1));
  assign w_last_row  = ({1'b0, row_cnt_q} == (rows_q - (ADDR_WIDTH + 1)'(1)));
  assign w_start_ok  = (state_q == S_IDLE) && start && (cfg_rows != '0) && (cfg_tiles != '0);
  // Final row of a tile is being written this cycle; bank bookkeeping happens at its end.
  assign w_row_done  = we_q && final_q;
  assign w_release   = bank_release && full_q[rd_bank_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_start_ok) state_d = S_FILL;
      S_FILL: begin
        if (w_row_done) begin
          if (tiles_q == 8'd1)          state_d = S_IDLE;
          else if (full_q[!wr_bank_q])  state_d = S_WAIT;
          else                          state_d = S_FILL;
        end
      end
      S_WAIT: if (!full_q[wr_bank_q]) state_d = S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    s_ready = (state_q == S_FILL) && !full_q[wr_bank_q] && !w_row_done;
  end

  always_comb begin
    rows_d        = rows_q;
    tiles_d       = tiles_q;
    row_cnt_d     = row_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    pack_d        = pack_q;
    we_d          = 1'b0;
    final_d       = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    bank_sel_wr_d = bank_sel_wr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    done_d        = 1'b0;

    if (w_start_ok) begin
      rows_d     = cfg_rows;
      tiles_d    = cfg_tiles;
      row_cnt_d  = '0;
      byte_cnt_d = '0;
    end

    if (w_accept) begin
      for (int k = 0; k < TN; k++) begin
        if (byte_cnt_q == BCW'(k)) pack_d[8*k +: 8] = s_data;
      end
      if (w_last_byte) begin
        byte_cnt_d    = '0;
        we_d          = 1'b1;
        final_d       = w_last_row;
        waddr_d       = row_cnt_q;
        wdata_d       = pack_d;
        bank_sel_wr_d = wr_bank_q;
        row_cnt_d     = row_cnt_q + ADDR_WIDTH'(1);
      end else begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
      end
    end

    if (w_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    // Bank toggles even on the last tile so the next job continues ping-pong order.
    if (w_row_done) begin
      full_d[wr_bank_q] = 1'b1;
      row_cnt_d         = '0;
      tiles_d           = tiles_q - 8'd1;
      wr_bank_d         = !wr_bank_q;
      done_d            = (tiles_q == 8'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q        <= '0;
      tiles_q       <= '0;
      row_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      pack_q        <= '0;
      we_q          <= 1'b0;
      final_q       <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      bank_sel_wr_q <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      done_q        <= 1'b0;
    end else begin
      rows_q        <= rows_d;
      tiles_q       <= tiles_d;
      row_cnt_q     <= row_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      pack_q        <= pack_d;
      we_q          <= we_d;
      final_q       <= final_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      bank_sel_wr_q <= bank_sel_wr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      done_q        <= done_d;
    end
  end

  assign we          = we_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign bank_sel_wr = bank_sel_wr_q;
  assign bank_valid  = full_q[rd_bank_q];
  assign bank_sel_rd = rd_bank_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_wgt_loader.sv
`default_nettype none
// ==========================================================================
// tb_wgt_loader : directed scoreboard bench for wgt_loader
// Revision      : 1.0
// ==========================================================================
module tb_wgt_loader;
  localparam int TN = 14;
  localparam int AW = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW:0]     cfg_rows = '0;
  logic [7:0]      cfg_tiles = '0;
  logic            s_valid = 1'b0;
  logic [7:0]      s_data = '0;
  logic            bank_release = 1'b0;
  logic            s_ready, we, bank_sel_wr, bank_valid, bank_sel_rd, busy, done;
  logic [AW-1:0]   waddr;
  logic [TN*8-1:0] wdata;

  always #5 clk = ~clk;

  wgt_loader #(.TN(TN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .bank_sel_wr(bank_sel_wr),
    .bank_valid(bank_valid), .bank_sel_rd(bank_sel_rd), .bank_release(bank_release),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            bank;
    logic [TN*8-1:0] data;
  } row_t;

  row_t exp_q[$];
  int   n_pass  = 0;
  int   n_chk   = 0;
  int   n_we    = 0;
  int   n_stall = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Scoreboard: every write pulse must match the oldest queued row.
  always @(negedge clk) begin
    row_t e;
    if (we === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        chk("we_unexpected", {127'd0, we}, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", {{(128-AW){1'b0}}, waddr}, {{(128-AW){1'b0}}, e.addr});
        chk("wdata", {{(128-TN*8){1'b0}}, wdata}, {{(128-TN*8){1'b0}}, e.data});
        chk("bank_sel_wr", {127'd0, bank_sel_wr}, {127'd0, e.bank});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input logic [AW:0] rows, input logic [7:0] tiles);
    cfg_rows  = rows;
    cfg_tiles = tiles;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 200) begin
      n++;
      n_stall++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", {127'd0, s_ready}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic stream_rows(input int nrows, input logic bank, input logic [7:0] base, input bit gaps);
    row_t e;
    for (int r = 0; r < nrows; r++) begin
      e.addr = AW'(r);
      e.bank = bank;
      e.data = '0;
      for (int k = 0; k < TN; k++)
        e.data[8*k +: 8] = gaps ? 8'($urandom) : base + 8'(r * TN + k);
      exp_q.push_back(e);
      for (int k = 0; k < TN; k++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          s_valid = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        send(e.data[8*k +: 8]);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {127'd0, done}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", {127'd0, we}, 128'd0);
    chk("rst_waddr", {121'd0, waddr}, 128'd0);
    chk("rst_wdata", {16'd0, wdata}, 128'd0);
    chk("rst_s_ready", {127'd0, s_ready}, 128'd0);
    chk("rst_bank_valid", {127'd0, bank_valid}, 128'd0);
    chk("rst_bank_sel_rd", {127'd0, bank_sel_rd}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    rst = 1'b0;
    tick();

    // Two rows, one tile, continuous stream 0x00..0x1B
    n_stall = 0;
    pulse_start(9'd2, 8'd1);
    chk("s1_busy", {127'd0, busy}, 128'd1);
    stream_rows(2, 1'b0, 8'h00, 1'b0);
    chk("s1_no_stall", 128'(n_stall), 128'd0);
    wait_done("s1_done");
    tick();
    chk("s1_done_one_cycle", {127'd0, done}, 128'd0);
    chk("s1_busy_end", {127'd0, busy}, 128'd0);
    chk("s1_bank_valid", {127'd0, bank_valid}, 128'd1);
    chk("s1_bank_sel_rd", {127'd0, bank_sel_rd}, 128'd0);
    chk("s1_queue", 128'(exp_q.size()), 128'd0);

    // Three tiles with no consumer: third tile must wait for a release
    do_reset();
    pulse_start(9'd1, 8'd3);
    stream_rows(1, 1'b0, 8'h40, 1'b0);
    stream_rows(1, 1'b1, 8'h60, 1'b0);
    repeat (3) tick();
    chk("s2_wait_busy", {127'd0, busy}, 128'd1);
    chk("s2_wait_s_ready", {127'd0, s_ready}, 128'd0);
    chk("s2_wait_bank_valid", {127'd0, bank_valid}, 128'd1);
    chk("s2_wait_sel_rd", {127'd0, bank_sel_rd}, 128'd0);
    chk("s2_queue_two", 128'(exp_q.size()), 128'd0);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    chk("s2_rel_sel_rd", {127'd0, bank_sel_rd}, 128'd1);
    chk("s2_rel_bank_valid", {127'd0, bank_valid}, 128'd1);
    stream_rows(1, 1'b0, 8'h80, 1'b0);
    wait_done("s2_done");
    chk("s2_queue", 128'(exp_q.size()), 128'd0);

    // Random valid gaps: same packing, exactly rows*tiles writes
    do_reset();
    n_we = 0;
    pulse_start(9'd3, 8'd2);
    stream_rows(3, 1'b0, 8'h00, 1'b1);
    stream_rows(3, 1'b1, 8'h00, 1'b1);
    wait_done("s3_done");
    chk("s3_we_count", 128'(n_we), 128'd6);
    chk("s3_queue", 128'(exp_q.size()), 128'd0);

    // Illegal starts and starts while busy are ignored
    do_reset();
    pulse_start(9'd0, 8'd1);
    chk("s4_rows0_busy", {127'd0, busy}, 128'd0);
    pulse_start(9'd2, 8'd0);
    chk("s4_tiles0_busy", {127'd0, busy}, 128'd0);
    pulse_start(9'd2, 8'd1);
    chk("s4_start_busy", {127'd0, busy}, 128'd1);
    pulse_start(9'd1, 8'd5);
    chk("s4_restart_busy", {127'd0, busy}, 128'd1);
    stream_rows(2, 1'b0, 8'hA0, 1'b0);
    wait_done("s4_done");
    tick();
    chk("s4_busy_end", {127'd0, busy}, 128'd0);
    chk("s4_queue", 128'(exp_q.size()), 128'd0);

    // Asynchronous reset mid-row: outputs clear at once, partial row dropped
    n_we = 0;
    pulse_start(9'd2, 8'd1);
    for (int i = 0; i < 5; i++) send(8'(8'hC0 + i));
    rst = 1'b1;
    #1;
    chk("s5_we", {127'd0, we}, 128'd0);
    chk("s5_waddr", {121'd0, waddr}, 128'd0);
    chk("s5_wdata", {16'd0, wdata}, 128'd0);
    chk("s5_bank_sel_wr", {127'd0, bank_sel_wr}, 128'd0);
    chk("s5_s_ready", {127'd0, s_ready}, 128'd0);
    chk("s5_bank_valid", {127'd0, bank_valid}, 128'd0);
    chk("s5_bank_sel_rd", {127'd0, bank_sel_rd}, 128'd0);
    chk("s5_busy", {127'd0, busy}, 128'd0);
    chk("s5_done", {127'd0, done}, 128'd0);
    tick();
    rst = 1'b0;
    s_valid = 1'b1;
    repeat (20) tick();
    s_valid = 1'b0;
    chk("s5_no_we", 128'(n_we), 128'd0);
    chk("s5_idle", {127'd0, busy}, 128'd0);

    // Release of bank 0 in the same cycle bank 1 is marked full
    do_reset();
    pulse_start(9'd1, 8'd2);
    stream_rows(1, 1'b0, 8'h11, 1'b0);
    stream_rows(1, 1'b1, 8'h22, 1'b0);
    chk("s6_we_cycle", {127'd0, we}, 128'd1);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    chk("s6_bank_valid", {127'd0, bank_valid}, 128'd1);
    chk("s6_bank_sel_rd", {127'd0, bank_sel_rd}, 128'd1);
    chk("s6_done", {127'd0, done}, 128'd1);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    chk("s6_bank0_freed", {127'd0, bank_valid}, 128'd0);
    chk("s6_sel_rd_back", {127'd0, bank_sel_rd}, 128'd0);
    chk("s6_queue", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wgt_loader.md
WGT_LOADER -- requirements
Module: wgt_loader

Interface
REQ-001 SHALL have parameter TN, default 14, meaning bytes per weight row (wdata width TN*8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, meaning weight-buffer row address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load job.
REQ-006 SHALL have port cfg_rows  input  ADDR_WIDTH+1  rows per bank, 1..2^ADDR_WIDTH, sampled on accepted start.
REQ-007 SHALL have port cfg_tiles  input  8  banks (tiles) to fill per job, 1..255, sampled on accepted start.
REQ-008 SHALL have port s_valid  input  1  weight byte valid.
REQ-009 SHALL have port s_data  input  8  weight byte (signed int8, passed through unmodified).
REQ-010 SHALL have port s_ready  output  1  loader accepts the byte this cycle.
REQ-011 SHALL have ports we (output, 1), waddr (output, ADDR_WIDTH), wdata (output, TN*8), and bank_sel_wr (output, 1), forming the weight-buffer write port.
REQ-012 SHALL have ports bank_valid (output, 1) and bank_sel_rd (output, 1), meaning that bank bank_sel_rd is full and readable.
REQ-013 SHALL have port bank_release  input  1  consumer pulse that frees bank bank_sel_rd.
REQ-014 SHALL have ports busy (output, 1), meaning a job is active, and done (output, 1), a one-cycle pulse when a job completes.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, and WAIT_BANK.
REQ-016 IDLE->FILL SHALL occur on start with cfg_rows!=0 and cfg_tiles!=0; any other start SHALL be ignored, including every start outside IDLE.
REQ-017 A byte SHALL be accepted when s_valid && s_ready.
REQ-018 s_ready SHALL be 1 only in FILL, with full[wr_bank]==0, and with no final-row write pending.
REQ-019 Byte counter 0..TN-1: the k-th accepted byte of a row SHALL land in wdata[8k+7:8k] (first byte in lane 0).
REQ-020 On acceptance of byte TN-1, the next cycle SHALL have we=1 with waddr=row counter, wdata=packed row, bank_sel_wr=wr_bank; the byte counter wraps to 0.
REQ-021 The loader SHALL accept a byte during the we cycle of a non-final row, giving zero stall between rows.
REQ-022 we SHALL be high for exactly one cycle per row; at all other times we=0, and waddr/wdata hold their last value.
REQ-023 The row counter SHALL increment after each write; after the write of row cfg_rows-1 the loader SHALL set full[wr_bank], clear the row counter, and decrement the remaining-tiles count.
REQ-024 If tiles remain after REQ-023: wr_bank SHALL toggle, with next state FILL if the new bank is free, else WAIT_BANK.
REQ-025 If no tiles remain after REQ-023: next state SHALL be IDLE, done=1 for one cycle, and wr_bank SHALL still toggle, keeping ping-pong order.
REQ-026 WAIT_BANK->FILL SHALL occur in the cycle after full[wr_bank] clears.
REQ-027 bank_sel_rd SHALL equal the rd_bank register, and bank_valid SHALL equal full[rd_bank].
REQ-028 bank_release while bank_valid=1 SHALL clear full[rd_bank] and toggle rd_bank on the same edge; bank_release while bank_valid=0 SHALL be ignored.
REQ-029 Setting full on one bank and releasing the other bank in the same cycle SHALL both take effect.
REQ-030 busy SHALL be 1 in FILL and WAIT_BANK, and 0 in IDLE.

Reset
REQ-031 rst SHALL force, asynchronously: state=IDLE, counters=0, wr_bank=0, rd_bank=0, full[1:0]=0, we=0, waddr=0, wdata=0, bank_sel_wr=0, s_ready=0, bank_valid=0, bank_sel_rd=0, busy=0, done=0.
REQ-032 rst mid-job SHALL abort the job; any partially packed row SHALL be discarded with no write issued.

Verification
REQ-033 SHALL cover: TN=14, cfg_rows=2, cfg_tiles=1, bytes 0x00..0x1B streamed continuously -> we at waddr 0 with wdata lane0=0x00..lane13=0x0D, we at waddr 1 with lanes 0x0E..0x1B, bank_valid=1 and bank_sel_rd=0, done pulse, busy=0.
REQ-034 SHALL cover: cfg_tiles=3, cfg_rows=1, no bank_release -> banks 0 and 1 fill, then WAIT_BANK with s_ready=0; one bank_release -> bank_sel_rd=1, third tile written to bank 0.
REQ-035 SHALL cover: s_valid toggled randomly -> packed lanes unchanged versus continuous stream, and exactly cfg_rows we pulses per tile.
REQ-036 SHALL cover: start with cfg_rows=0, or start while busy -> no state change, busy unchanged.
REQ-037 SHALL cover: rst asserted after 5 bytes of row 0 -> all outputs at reset values immediately, with no we afterwards until a new start.
REQ-038 SHALL cover: bank_release in the same cycle as the final row completes on the other bank -> bank_valid stays 1, bank_sel_rd toggles, and the written bank is marked full.
